// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types, defaults and helpers for the sequence-detector
// lab blocks. The bitstream_serializer imports it for its FSM state type and
// its pattern-length clamp.
package seqdet_pkg;

  // Serializer FSM: waiting for a pattern, or shifting one out.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH_DEF    = 8;
  localparam int SER_TICK_DIV_DEF = 1;

  // Limit a requested pattern length to the pattern register width.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    return (len > width) ? width : len;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock into bit periods of TICK_DIV cycles.
// 'first' is high in the first cycle of a period, 'wrap' in the last one
// (both together when TICK_DIV is 1). The count restarts from zero on
// reset or clear so a new pattern always begins with a full bit period.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic wrap
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Period counter: 0..TICK_DIV-1 while enabled, forced to 0 on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      if (cnt_reg == CNT_MAX) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign first = (cnt_reg == '0);
  assign wrap  = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/bitstream_serializer.sv
// bitstream_serializer: accepts a parallel pattern over load_valid/load_ready
// and shifts it out one bit per TICK_DIV clocks on serial_out, with a
// per-bit strobe and a done pulse one cycle after the final bit.
// Optional looping (port loop_mode) is built in when the macro
// BITSTREAM_LOOP_EN is defined; otherwise each pattern is sent once.
module bitstream_serializer
  import seqdet_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter int TICK_DIV  = SER_TICK_DIV_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [WIDTH-1:0]           load_data,
  input  logic [$clog2(WIDTH+1)-1:0] load_len,
  input  logic                       abort,
`ifdef BITSTREAM_LOOP_EN
  input  logic                       loop_mode,
`endif
  output logic                       serial_out,
  output logic                       serial_valid,
  output logic                       bit_strobe,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(WIDTH + 1);

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [LEN_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [LEN_W-1:0] eff_len_reg, eff_len_next;
  logic             done_reg, done_next;
`ifdef BITSTREAM_LOOP_EN
  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic             loop_reg, loop_next;
`endif

  logic             handshake;
  logic [LEN_W-1:0] load_eff_len;
  logic             head_bit;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             tick_first;
  logic             tick_wrap;

  assign handshake    = (state_reg == SER_IDLE) && load_valid;
  assign load_eff_len = LEN_W'(clamp_len(32'(load_len), 32'(WIDTH)));
  assign last_bit     = ((bit_cnt_reg + LEN_W'(1)) == eff_len_reg);

  // Bit order: the head bit is what serial_out shows; shifting brings the
  // next pattern bit into the head position.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign head_bit = shift_reg[WIDTH-1];
      assign shifted  = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit = shift_reg[0];
      assign shifted  = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // Bit-period timing restarts on every accepted pattern and on abort.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (handshake || abort),
    .enable (state_reg == SER_SHIFT),
    .first  (tick_first),
    .wrap   (tick_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SER_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: pattern shifter, bit counter, length, done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      eff_len_reg <= '0;
      done_reg    <= 1'b0;
`ifdef BITSTREAM_LOOP_EN
      pattern_reg <= '0;
      loop_reg    <= 1'b0;
`endif
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      eff_len_reg <= eff_len_next;
      done_reg    <= done_next;
`ifdef BITSTREAM_LOOP_EN
      pattern_reg <= pattern_next;
      loop_reg    <= loop_next;
`endif
    end
  end

  // Next-state and output logic; abort beats the end-of-pattern step so an
  // aborted pattern never produces done.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    eff_len_next = eff_len_reg;
    done_next    = 1'b0;
`ifdef BITSTREAM_LOOP_EN
    pattern_next = pattern_reg;
    loop_next    = loop_reg;
`endif
    load_ready   = 1'b0;
    busy         = 1'b0;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    bit_strobe   = 1'b0;

    case (state_reg)
      SER_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shift_next   = load_data;
          eff_len_next = load_eff_len;
          bit_cnt_next = '0;
`ifdef BITSTREAM_LOOP_EN
          pattern_next = load_data;
          loop_next    = loop_mode;
`endif
          if (load_eff_len == '0) begin
            // Nothing to send: acknowledge with done straight away.
            done_next = 1'b1;
          end else begin
            state_next = SER_SHIFT;
          end
        end
      end

      SER_SHIFT: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_out   = head_bit;
        bit_strobe   = tick_first;
        if (abort) begin
          state_next   = SER_IDLE;
          shift_next   = '0;
          bit_cnt_next = '0;
        end else if (tick_wrap) begin
          if (last_bit) begin
            done_next    = 1'b1;
            bit_cnt_next = '0;
`ifdef BITSTREAM_LOOP_EN
            if (loop_reg) begin
              // Restart the same pattern with no idle cycle in between.
              shift_next = pattern_reg;
            end else begin
              state_next = SER_IDLE;
              shift_next = '0;
            end
`else
            state_next = SER_IDLE;
            shift_next = '0;
`endif
          end else begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + LEN_W'(1);
          end
        end
      end

      default: begin
        state_next = SER_IDLE;
      end
    endcase
  end

  assign done = done_reg;

endmodule

// File: tb/tb_bitstream_serializer.sv
// tb_bitstream_serializer: directed stimulus on two serializer instances
// (one bit per clock MSB-first, and three clocks per bit LSB-first).
// Expected serial bits are queued when a pattern is offered and popped by a
// monitor on every bit strobe; cycle-exact checks cover handshake, latency,
// done, abort and reset behaviour.
module tb_bitstream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_load_valid, a_load_ready, a_abort;
  logic [7:0] a_load_data;
  logic [3:0] a_load_len;
  logic       a_serial_out, a_serial_valid, a_bit_strobe, a_busy, a_done;

  logic       b_load_valid, b_load_ready, b_abort;
  logic [7:0] b_load_data;
  logic [3:0] b_load_len;
  logic       b_serial_out, b_serial_valid, b_bit_strobe, b_busy, b_done;

`ifdef BITSTREAM_LOOP_EN
  logic a_loop_mode;
`endif

  int checks = 0;
  int errors = 0;
  bit q_a[$];
  bit q_b[$];

  bitstream_serializer #(.WIDTH(8), .TICK_DIV(1), .MSB_FIRST(1)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (a_load_valid),
    .load_ready   (a_load_ready),
    .load_data    (a_load_data),
    .load_len     (a_load_len),
    .abort        (a_abort),
`ifdef BITSTREAM_LOOP_EN
    .loop_mode    (a_loop_mode),
`endif
    .serial_out   (a_serial_out),
    .serial_valid (a_serial_valid),
    .bit_strobe   (a_bit_strobe),
    .busy         (a_busy),
    .done         (a_done)
  );

  bitstream_serializer #(.WIDTH(8), .TICK_DIV(3), .MSB_FIRST(0)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (b_load_valid),
    .load_ready   (b_load_ready),
    .load_data    (b_load_data),
    .load_len     (b_load_len),
    .abort        (b_abort),
`ifdef BITSTREAM_LOOP_EN
    .loop_mode    (1'b0),
`endif
    .serial_out   (b_serial_out),
    .serial_valid (b_serial_valid),
    .bit_strobe   (b_bit_strobe),
    .busy         (b_busy),
    .done         (b_done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bit order for instance A: MSB first, length clamped to 8.
  task automatic push_a(input logic [7:0] d, input int len);
    int e;
    e = (len > 8) ? 8 : len;
    for (int i = 0; i < e; i++) q_a.push_back(d[7-i]);
  endtask

  // Expected bit order for instance B: LSB first.
  task automatic push_b(input logic [7:0] d, input int len);
    int e;
    e = (len > 8) ? 8 : len;
    for (int i = 0; i < e; i++) q_b.push_back(d[i]);
  endtask

  // Scoreboard monitors: each bit strobe must match the next queued bit.
  always @(negedge clk) begin
    if (!reset && a_bit_strobe) begin
      logic e;
      e = (q_a.size() != 0) ? q_a.pop_front() : 1'bx;
      chk1("sb_a_bit", a_serial_out, e);
    end
  end

  always @(negedge clk) begin
    if (!reset && b_bit_strobe) begin
      logic e;
      e = (q_b.size() != 0) ? q_b.pop_front() : 1'bx;
      chk1("sb_b_bit", b_serial_out, e);
    end
  end

  initial begin
    logic [7:0] pat;
    int         n;
    logic       seen;

    reset = 1'b1;
    a_load_valid = 1'b0; a_load_data = '0; a_load_len = '0; a_abort = 1'b0;
    b_load_valid = 1'b0; b_load_data = '0; b_load_len = '0; b_abort = 1'b0;
`ifdef BITSTREAM_LOOP_EN
    a_loop_mode = 1'b0;
`endif
    tick();
    tick();
    chk1("rst_serial_out", a_serial_out, 1'b0);
    chk1("rst_serial_valid", a_serial_valid, 1'b0);
    chk1("rst_bit_strobe", a_bit_strobe, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_done", a_done, 1'b0);
    chk1("rst_load_ready", a_load_ready, 1'b1);
    chk1("rst_b_load_ready", b_load_ready, 1'b1);
    reset = 1'b0;
    tick();

    // A0, 3 bits, MSB first: 1,0,1 in cycles 1-3, done in cycle 4.
    a_load_data = 8'hA0; a_load_len = 4'd3; a_load_valid = 1'b1;
    push_a(8'hA0, 3);
    tick();
    a_load_valid = 1'b0;
    chk1("t1_c1_out", a_serial_out, 1'b1);
    chk1("t1_c1_strobe", a_bit_strobe, 1'b1);
    chk1("t1_c1_busy", a_busy, 1'b1);
    chk1("t1_c1_ready", a_load_ready, 1'b0);
    tick();
    chk1("t1_c2_out", a_serial_out, 1'b0);
    chk1("t1_c2_valid", a_serial_valid, 1'b1);
    tick();
    chk1("t1_c3_out", a_serial_out, 1'b1);
    chk1("t1_c3_done", a_done, 1'b0);
    tick();
    chk1("t1_c4_done", a_done, 1'b1);
    chk1("t1_c4_valid", a_serial_valid, 1'b0);
    chk1("t1_c4_busy", a_busy, 1'b0);
    chk1("t1_c4_ready", a_load_ready, 1'b1);
    tick();
    chk1("t1_c5_done", a_done, 1'b0);

    // 05, 4 bits, LSB first, 3 clocks per bit: strobes 1,4,7,10, done 13.
    pat = 8'h05;
    b_load_data = pat; b_load_len = 4'd4; b_load_valid = 1'b1;
    push_b(pat, 4);
    tick();
    b_load_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk1("t2_out", b_serial_out, (c <= 12) ? pat[(c-1)/3] : 1'b0);
      chk1("t2_valid", b_serial_valid, c <= 12);
      chk1("t2_strobe", b_bit_strobe, (c <= 12) && ((c - 1) % 3 == 0));
      chk1("t2_done", b_done, c == 13);
      tick();
    end

    // Zero-length pattern: no serial_valid, done next cycle.
    a_load_data = 8'hFF; a_load_len = 4'd0; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    chk1("t3_len0_done", a_done, 1'b1);
    chk1("t3_len0_valid", a_serial_valid, 1'b0);
    chk1("t3_len0_ready", a_load_ready, 1'b1);
    tick();
    chk1("t3_len0_done_clr", a_done, 1'b0);
    chk1("t3_len0_valid2", a_serial_valid, 1'b0);

    // Over-long pattern: length 12 on an 8-bit register sends 8 bits.
    a_load_data = 8'h96; a_load_len = 4'd12; a_load_valid = 1'b1;
    push_a(8'h96, 12);
    tick();
    a_load_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (a_serial_valid) n++;
      if (a_done) seen = 1'b1;
      else tick();
    end
    chkn("t3_len12_bits", n, 8);
    chk1("t3_len12_done", seen, 1'b1);
    tick();

    // Back-to-back: load_valid held; second pattern accepted in the done
    // cycle and its first bit follows immediately after it.
    a_load_data = 8'hC0; a_load_len = 4'd2; a_load_valid = 1'b1;
    push_a(8'hC0, 2);
    tick();
    a_load_data = 8'h40;
    push_a(8'h40, 2);
    chk1("t4_c1_valid", a_serial_valid, 1'b1);
    chk1("t4_c1_ready", a_load_ready, 1'b0);
    tick();
    chk1("t4_c2_valid", a_serial_valid, 1'b1);
    chk1("t4_c2_ready", a_load_ready, 1'b0);
    tick();
    chk1("t4_c3_done", a_done, 1'b1);
    chk1("t4_c3_ready", a_load_ready, 1'b1);
    tick();
    a_load_valid = 1'b0;
    chk1("t4_c4_valid", a_serial_valid, 1'b1);
    chk1("t4_c4_out", a_serial_out, 1'b0);
    chk1("t4_c4_done", a_done, 1'b0);
    tick();
    chk1("t4_c5_valid", a_serial_valid, 1'b1);
    chk1("t4_c5_out", a_serial_out, 1'b1);
    tick();
    chk1("t4_c6_done", a_done, 1'b1);
    chk1("t4_c6_valid", a_serial_valid, 1'b0);
    tick();

    // Abort during the second bit of a 5-bit pattern.
    a_load_data = 8'hF8; a_load_len = 4'd5; a_load_valid = 1'b1;
    push_a(8'hF8, 5);
    tick();
    a_load_valid = 1'b0;
    tick();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk1("t5_abort_valid", a_serial_valid, 1'b0);
    chk1("t5_abort_busy", a_busy, 1'b0);
    chk1("t5_abort_ready", a_load_ready, 1'b1);
    chk1("t5_abort_done", a_done, 1'b0);
    chk1("t5_abort_out", a_serial_out, 1'b0);
    q_a.delete();
    tick();
    chk1("t5_abort_done2", a_done, 1'b0);

    // Same again with reset instead of abort.
    a_load_data = 8'hF8; a_load_len = 4'd5; a_load_valid = 1'b1;
    push_a(8'hF8, 5);
    tick();
    a_load_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("t5_rst_valid", a_serial_valid, 1'b0);
    chk1("t5_rst_busy", a_busy, 1'b0);
    chk1("t5_rst_ready", a_load_ready, 1'b1);
    chk1("t5_rst_done", a_done, 1'b0);
    q_a.delete();
    tick();
    chk1("t5_rst_done2", a_done, 1'b0);

    // Abort together with a handshake while idle: the handshake wins.
    a_load_data = 8'h80; a_load_len = 4'd1; a_load_valid = 1'b1; a_abort = 1'b1;
    push_a(8'h80, 1);
    tick();
    a_load_valid = 1'b0; a_abort = 1'b0;
    chk1("t6_valid", a_serial_valid, 1'b1);
    chk1("t6_out", a_serial_out, 1'b1);
    tick();
    chk1("t6_done", a_done, 1'b1);
    tick();

`ifdef BITSTREAM_LOOP_EN
    // Looping 101 pattern: continuous output, done every third cycle.
    pat = 8'hA0;
    a_load_data = pat; a_load_len = 4'd3; a_load_valid = 1'b1; a_loop_mode = 1'b1;
    for (int p = 0; p < 4; p++) push_a(pat, 3);
    tick();
    a_load_valid = 1'b0; a_loop_mode = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk1("t7_out", a_serial_out, pat[7 - ((c - 1) % 3)]);
      chk1("t7_valid", a_serial_valid, 1'b1);
      chk1("t7_done", a_done, (c >= 4) && ((c - 1) % 3 == 0));
      if (c == 10) a_abort = 1'b1;
      tick();
    end
    a_abort = 1'b0;
    chk1("t7_abort_valid", a_serial_valid, 1'b0);
    chk1("t7_abort_ready", a_load_ready, 1'b1);
    chk1("t7_abort_done", a_done, 1'b0);
    q_a.delete();
    tick();
`endif

    chkn("sb_a_drained", q_a.size(), 0);
    chkn("sb_b_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
